spi_dac_tx: RTL and testbench

SPI transmitter on the far end of the sweep counter's `spi_start`/`voltage` interface.
- On each request it latches the 8-bit voltage code and serializes one 16-bit write frame to the external DAC that biases the photodiode.
- Reports `busy` and `done` back to the counter.
- Sits between the counter and the DAC pins, in the 50 MHz `clk` domain.

---
 rtl/dac_spi_pkg.sv | 14 +
 rtl/spi_dac_tx_sclk_divider.sv | 46 ++++
 rtl/spi_dac_tx.sv | 153 +++++++++++++++
 tb/tb_spi_dac_tx.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_spi_pkg.sv
// Shared types and frame helper for the photodiode-bias DAC SPI transmitter.
package dac_spi_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_e;

  localparam int unsigned FRAME_W = 16;
  localparam logic [3:0]  DEF_CMD = 4'b0011;

  // DAC write frame: command nibble, 8-bit code, four don't-care LSBs sent as zero.
  function automatic logic [FRAME_W-1:0] build_frame(input logic [3:0] cmd, input logic [7:0] code);
    return {cmd, code, 4'b0000};
  endfunction

endpackage

// File: rtl/spi_dac_tx_sclk_divider.sv
// SCLK generator: CLK_DIV clocks low then CLK_DIV clocks high while enabled,
// with one-cycle strobes in the cycle before each sclk edge.
module sclk_divider #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  output logic rise_o,
  output logic fall_o,
  output logic sclk_o
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sclk_q, sclk_d;
  logic          last;

  assign last = (cnt_q == CW'(CLK_DIV - 1));

  // Disabled means parked: counter cleared and sclk low, so every frame starts on a low phase.
  always_comb begin
    cnt_d  = '0;
    sclk_d = 1'b0;
    if (en_i) begin
      cnt_d  = last ? '0 : cnt_q + 1'b1;
      sclk_d = last ? ~sclk_q : sclk_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  assign rise_o = en_i && last && !sclk_q;
  assign fall_o = en_i && last && sclk_q;
  assign sclk_o = sclk_q;

endmodule

// File: rtl/spi_dac_tx.sv
// Mode-0 SPI writer for the bias DAC: one 16-bit frame per accepted request.
// SPI_DOUBLE_BUFFER_EN adds a one-entry pending request captured while busy.
module spi_dac_tx import dac_spi_pkg::*; #(
  parameter int unsigned CLK_DIV  = 4,
  parameter logic [3:0]  CMD      = DEF_CMD,
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_HOLD  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_start,
  input  logic [7:0] voltage,
  output logic       busy,
  output logic       done,
  output logic       dropped,
  output logic       sclk,
  output logic       mosi,
  output logic       cs_n
);

  localparam int unsigned TW = 8;

  state_e             state_q, state_d;
  logic [FRAME_W-1:0] sh_q, sh_d;
  logic [4:0]         bit_q, bit_d;
  logic [TW-1:0]      tmr_q, tmr_d;
  logic               cs_n_q, cs_n_d, busy_q, busy_d, done_q, done_d, dropped_q, dropped_d;
  logic               go;
  logic [7:0]         go_code;
  logic               rise, fall;
`ifdef SPI_DOUBLE_BUFFER_EN
  logic [7:0]         pend_q, pend_d;
  logic               pvld_q, pvld_d;
`endif

  sclk_divider #(.CLK_DIV(CLK_DIV)) u_div (
    .clk   (clk),
    .reset (reset),
    .en_i  (state_q == SHIFT),
    .rise_o(rise),
    .fall_o(fall),
    .sclk_o(sclk)
  );

  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    bit_d     = bit_q;
    tmr_d     = tmr_q;
    cs_n_d    = cs_n_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dropped_d = 1'b0;
    go        = 1'b0;
    go_code   = voltage;
`ifdef SPI_DOUBLE_BUFFER_EN
    pend_d = pend_q;
    pvld_d = pvld_q;
    // The IDLE gap before a pending launch is still busy; a request there refills the slot, no loss.
    if (spi_start && busy_q) begin
      pend_d    = voltage;
      pvld_d    = 1'b1;
      dropped_d = pvld_q && (state_q != IDLE);
    end
    if (state_q == IDLE) begin
      go = pvld_q || spi_start;
      if (pvld_q) begin
        go_code = pend_q;
        if (!spi_start) pvld_d = 1'b0;
      end
    end
`else
    dropped_d = spi_start && busy_q;
    go        = (state_q == IDLE) && spi_start;
`endif

    case (state_q)
      IDLE: if (go) begin
        state_d = SETUP;
        sh_d    = build_frame(CMD, go_code);
        bit_d   = '0;
        tmr_d   = '0;
        cs_n_d  = 1'b0;
        busy_d  = 1'b1;
      end
      SETUP: if (tmr_q == TW'(CS_SETUP - 1)) begin
        state_d = SHIFT;
        tmr_d   = '0;
      end else begin
        tmr_d = tmr_q + 1'b1;
      end
      SHIFT: begin
        if (rise) bit_d = bit_q + 5'd1;
        // Shifting on the fall also zeroes mosi after the last bit.
        if (fall) begin
          sh_d = sh_q << 1;
          if (bit_q == 5'(FRAME_W)) state_d = HOLD;
        end
      end
      HOLD: if (tmr_q == TW'(CS_HOLD - 1)) begin
        state_d = IDLE;
        tmr_d   = '0;
        cs_n_d  = 1'b1;
        done_d  = 1'b1;
`ifdef SPI_DOUBLE_BUFFER_EN
        busy_d  = pvld_d;
`else
        busy_d  = 1'b0;
`endif
      end else begin
        tmr_d = tmr_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      sh_q      <= '0;
      bit_q     <= '0;
      tmr_q     <= '0;
      cs_n_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dropped_q <= 1'b0;
`ifdef SPI_DOUBLE_BUFFER_EN
      pend_q    <= '0;
      pvld_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      sh_q      <= sh_d;
      bit_q     <= bit_d;
      tmr_q     <= tmr_d;
      cs_n_q    <= cs_n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dropped_q <= dropped_d;
`ifdef SPI_DOUBLE_BUFFER_EN
      pend_q    <= pend_d;
      pvld_q    <= pvld_d;
`endif
    end
  end

  assign mosi    = sh_q[FRAME_W-1];
  assign cs_n    = cs_n_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign dropped = dropped_q;

endmodule

// File: tb/tb_spi_dac_tx.sv
// Directed bench for spi_dac_tx: a pin-level SPI receiver collects frames and timing.
module tb_spi_dac_tx;

  logic       clk = 1'b0, reset = 1'b0, spi_start = 1'b0;
  logic [7:0] voltage = 8'h00;
  logic       busy, done, dropped, sclk, mosi, cs_n;
  int         vecs = 0, errs = 0;

  spi_dac_tx dut (
    .clk(clk), .reset(reset), .spi_start(spi_start), .voltage(voltage),
    .busy(busy), .done(done), .dropped(dropped), .sclk(sclk), .mosi(mosi), .cs_n(cs_n)
  );

  always #10 clk = ~clk;

  // Receiver model sampled on the falling clk edge, away from DUT updates.
  logic        sclk_p = 1'b0, mosi_p = 1'b0, cs_n_p = 1'b1;
  logic [15:0] rx = '0;
  int          rx_bits = 0, cs_low_cnt = 0, done_cnt = 0, drop_cnt = 0;
  int          unstable = 0, aborts = 0, hi_run = 0;
  logic [15:0] frames[$];
  int          gaps[$];

  always @(negedge clk) begin
    sclk_p <= sclk;
    mosi_p <= mosi;
    cs_n_p <= cs_n;
    if (!cs_n) cs_low_cnt <= cs_low_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (dropped) drop_cnt <= drop_cnt + 1;
    if (cs_n) hi_run <= hi_run + 1;
    else      hi_run <= 0;
    if (!cs_n && cs_n_p) gaps.push_back(hi_run);
    if (cs_n) rx_bits <= 0;
    else if (sclk && !sclk_p) begin
      rx      <= {rx[14:0], mosi};
      rx_bits <= rx_bits + 1;
      if (mosi !== mosi_p) unstable <= unstable + 1;
    end
    if (cs_n && !cs_n_p) begin
      if (rx_bits == 16) frames.push_back(rx);
      else               aborts <= aborts + 1;
    end
  end

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done && cyc < 300);
    if (!done) cyc = -1;
  endtask

  task automatic send_one(input logic [7:0] v, output int lat);
    int c;
    spi_start = 1'b1; voltage = v;
    @(negedge clk);
    spi_start = 1'b0;
    wait_done(c);
    lat = (c < 0) ? -1 : c + 1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    vecs++; if (cs_n !== 1'b1)    begin errs++; $display("FAIL reset_cs_n got %b want 1", cs_n); end
    vecs++; if (sclk !== 1'b0)    begin errs++; $display("FAIL reset_sclk got %b want 0", sclk); end
    vecs++; if (mosi !== 1'b0)    begin errs++; $display("FAIL reset_mosi got %b want 0", mosi); end
    vecs++; if (busy !== 1'b0)    begin errs++; $display("FAIL reset_busy got %b want 0", busy); end
    vecs++; if (done !== 1'b0)    begin errs++; $display("FAIL reset_done got %b want 0", done); end
    vecs++; if (dropped !== 1'b0) begin errs++; $display("FAIL reset_dropped got %b want 0", dropped); end
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    int nf, cl, dc, c, lat;
    logic [15:0] f;
    @(negedge clk); #1;
    nf = frames.size(); cl = cs_low_cnt; dc = done_cnt;
    spi_start = 1'b1; voltage = 8'hA5;
    @(negedge clk);
    spi_start = 1'b0;
    vecs++; if (busy !== 1'b1 || cs_n !== 1'b0) begin errs++; $display("FAIL single_accept got busy=%b cs_n=%b want 1/0", busy, cs_n); end
    wait_done(c);
    lat = (c < 0) ? -1 : c + 1;
    vecs++; if (lat !== 133) begin errs++; $display("FAIL single_latency got %0d want 133", lat); end
    vecs++; if (busy !== 1'b0 || cs_n !== 1'b1) begin errs++; $display("FAIL single_end got busy=%b cs_n=%b want 0/1", busy, cs_n); end
    @(negedge clk); #1;
    vecs++; if (done !== 1'b0) begin errs++; $display("FAIL single_done_width got %b want 0", done); end
    f = (frames.size() > nf) ? frames[nf] : 16'hxxxx;
    vecs++; if (f !== 16'h3A50) begin errs++; $display("FAIL single_frame got %h want 3a50", f); end
    vecs++; if (cs_low_cnt - cl !== 132) begin errs++; $display("FAIL single_cs_low got %0d want 132", cs_low_cnt - cl); end
    vecs++; if (done_cnt - dc !== 1) begin errs++; $display("FAIL single_done_count got %0d want 1", done_cnt - dc); end
  endtask

  task automatic test_boundary();
    logic [7:0]  codes[2] = '{8'h00, 8'hFF};
    logic [15:0] exp[2]   = '{16'h3000, 16'h3FF0};
    int nf, us, lat;
    logic [15:0] f;
    @(negedge clk); #1;
    us = unstable;
    for (int i = 0; i < 2; i++) begin
      nf = frames.size();
      send_one(codes[i], lat);
      vecs++; if (lat !== 133) begin errs++; $display("FAIL boundary_latency[%0d] got %0d want 133", i, lat); end
      @(negedge clk); #1;
      f = (frames.size() > nf) ? frames[nf] : 16'hxxxx;
      vecs++; if (f !== exp[i]) begin errs++; $display("FAIL boundary_frame[%0d] got %h want %h", i, f, exp[i]); end
    end
    vecs++; if (unstable !== us) begin errs++; $display("FAIL mosi_stable_at_rise got %0d changes want 0", unstable - us); end
  endtask

`ifndef SPI_DOUBLE_BUFFER_EN
  task automatic test_drop();
    int nf, dc, dr, c, lat;
    logic [15:0] f;
    @(negedge clk); #1;
    nf = frames.size(); dc = done_cnt; dr = drop_cnt;
    spi_start = 1'b1; voltage = 8'h5A;
    @(negedge clk);
    spi_start = 1'b0;
    repeat (48) @(negedge clk);
    spi_start = 1'b1; voltage = 8'h10;
    @(negedge clk);
    spi_start = 1'b0;
    wait_done(c);
    lat = (c < 0) ? -1 : c + 50;
    vecs++; if (lat !== 133) begin errs++; $display("FAIL drop_latency got %0d want 133", lat); end
    repeat (10) @(negedge clk); #1;
    vecs++; if (drop_cnt - dr !== 1) begin errs++; $display("FAIL drop_pulses got %0d want 1", drop_cnt - dr); end
    vecs++; if (frames.size() - nf !== 1) begin errs++; $display("FAIL drop_frames got %0d want 1", frames.size() - nf); end
    f = (frames.size() > nf) ? frames[nf] : 16'hxxxx;
    vecs++; if (f !== 16'h35A0) begin errs++; $display("FAIL drop_frame got %h want 35a0", f); end
    vecs++; if (done_cnt - dc !== 1) begin errs++; $display("FAIL drop_done_count got %0d want 1", done_cnt - dc); end
  endtask
`else
  task automatic test_double_buffer();
    int nf, dr, g0, cyc, d1, d2, blow;
    logic [15:0] f0, f1;
    @(negedge clk); #1;
    nf = frames.size(); dr = drop_cnt; g0 = gaps.size();
    spi_start = 1'b1; voltage = 8'h40;
    cyc = 0; d1 = 0; d2 = 0; blow = 0;
    while (d2 == 0 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (done) begin if (d1 == 0) d1 = cyc; else d2 = cyc; end
      if (!busy && d2 == 0) blow++;
      spi_start = (cyc == 30 || cyc == 50);
      if (cyc == 30) voltage = 8'h20;
      if (cyc == 50) voltage = 8'h21;
    end
    vecs++; if (d1 !== 133) begin errs++; $display("FAIL dbuf_first_done got %0d want 133", d1); end
    vecs++; if (d2 - d1 !== 133) begin errs++; $display("FAIL dbuf_second_done got %0d want 133", d2 - d1); end
    vecs++; if (blow !== 0) begin errs++; $display("FAIL dbuf_busy_gap got %0d low cycles want 0", blow); end
    repeat (5) @(negedge clk); #1;
    vecs++; if (drop_cnt - dr !== 1) begin errs++; $display("FAIL dbuf_dropped got %0d want 1", drop_cnt - dr); end
    f0 = (frames.size() > nf) ? frames[nf] : 16'hxxxx;
    f1 = (frames.size() > nf + 1) ? frames[nf+1] : 16'hxxxx;
    vecs++; if (f0 !== 16'h3400 || f1 !== 16'h3210) begin errs++; $display("FAIL dbuf_frames got %h %h want 3400 3210", f0, f1); end
    vecs++; if (gaps.size() < g0 + 2 || gaps[g0+1] !== 1) begin errs++; $display("FAIL dbuf_cs_gap got %0d want 1", (gaps.size() > g0 + 1) ? gaps[g0+1] : -1); end
  endtask
`endif

  task automatic test_reset_mid();
    int dc, ab, nf, lat;
    logic [15:0] f;
    @(negedge clk); #1;
    dc = done_cnt; ab = aborts;
    spi_start = 1'b1; voltage = 8'h77;
    @(negedge clk);
    spi_start = 1'b0;
    repeat (63) @(negedge clk); #1;
    vecs++; if (sclk !== 1'b1 || cs_n !== 1'b0) begin errs++; $display("FAIL midframe_phase got sclk=%b cs_n=%b want 1/0", sclk, cs_n); end
    reset = 1'b0; #1;
    vecs++; if (cs_n !== 1'b1 || sclk !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL async_reset got cs_n=%b sclk=%b busy=%b want 1/0/0", cs_n, sclk, busy); end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk); #1;
    vecs++; if (done_cnt !== dc) begin errs++; $display("FAIL abort_done got %0d pulses want 0", done_cnt - dc); end
    vecs++; if (aborts - ab !== 1) begin errs++; $display("FAIL abort_count got %0d want 1", aborts - ab); end
    nf = frames.size();
    send_one(8'h3C, lat);
    vecs++; if (lat !== 133) begin errs++; $display("FAIL post_reset_latency got %0d want 133", lat); end
    @(negedge clk); #1;
    f = (frames.size() > nf) ? frames[nf] : 16'hxxxx;
    vecs++; if (f !== 16'h33C0) begin errs++; $display("FAIL post_reset_frame got %h want 33c0", f); end
  endtask

  task automatic test_back_to_back();
    int nf, g0, c;
    int lat[3];
    logic [15:0] exp[3] = '{16'h3010, 16'h3020, 16'h3030};
    logic [15:0] f;
    @(negedge clk); #1;
    nf = frames.size(); g0 = gaps.size();
    spi_start = 1'b1; voltage = 8'h01;
    @(negedge clk);
    voltage = 8'h02;
    wait_done(c); lat[0] = (c < 0) ? -1 : c + 1;
    @(negedge clk);
    voltage = 8'h03;
    wait_done(c); lat[1] = (c < 0) ? -1 : c + 1;
    @(negedge clk);
    spi_start = 1'b0;
    wait_done(c); lat[2] = (c < 0) ? -1 : c + 1;
    repeat (3) @(negedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      vecs++; if (lat[i] !== 133) begin errs++; $display("FAIL b2b_latency[%0d] got %0d want 133", i, lat[i]); end
      f = (frames.size() > nf + i) ? frames[nf+i] : 16'hxxxx;
      vecs++; if (f !== exp[i]) begin errs++; $display("FAIL b2b_frame[%0d] got %h want %h", i, f, exp[i]); end
    end
    for (int i = 1; i < 3; i++) begin
      vecs++; if (gaps.size() <= g0 + i || gaps[g0+i] !== 1) begin errs++; $display("FAIL b2b_cs_gap[%0d] got %0d want 1", i, (gaps.size() > g0 + i) ? gaps[g0+i] : -1); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_boundary();
`ifdef SPI_DOUBLE_BUFFER_EN
    test_double_buffer();
`else
    test_drop();
`endif
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired after %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
